// File: rtl/seq_calc.sv
// seq_calc: registered signed calculator with valid/ready in and out.
// Ops: add, sub, abs, accumulate, and an optional shift-add multiply.
// Build option: define SEQ_CALC_MUL_EN to include the multiplier. Without it,
// op 011 behaves as |b| with single-cycle latency and busy is tied low.
module seq_calc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             ovf,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             sticky_q;
  logic             busy_q;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH:0]   abs_a;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH:0]   sc_res;

  // Signed add/sub; returns {overflow, wrapped result}.
  function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic             sub);
    logic [WIDTH-1:0] yy;
    logic [WIDTH-1:0] s;
    logic             o;
    yy = sub ? ~y : y;
    s  = x + yy + WIDTH'(sub);
    o  = (x[WIDTH-1] == yy[WIDTH-1]) & (s[WIDTH-1] != x[WIDTH-1]);
    return {o, s};
  endfunction

  // Absolute value; the most-negative input wraps to itself and flags overflow.
  function automatic logic [WIDTH:0] absv(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] m;
    m = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    return {x[WIDTH-1] & ~(|x[WIDTH-2:0]), m};
  endfunction

  assign in_ready   = ~rst & ((state_q == S_IDLE) | ((state_q == S_RESULT) & out_ready));
  assign accept     = in_valid & in_ready;
  assign deliver    = out_valid_q & out_ready;
  // A result delivered on the acceptance edge is already visible to op 111.
  assign acc_eff    = deliver ? r_q : acc_q;

  assign out_valid  = out_valid_q;
  assign r          = r_q;
  assign ovf        = ovf_q;
  assign sticky_ovf = sticky_q;
  assign busy       = busy_q;

  // Single-cycle result selection from the live request.
  always_comb begin
    abs_a  = absv(a);
    abs_b  = absv(b);
    sc_res = '0;
    case (op)
      3'b000:  sc_res = addsub(a, b, 1'b0);
      3'b001:  sc_res = addsub(a, b, 1'b1);
      3'b010:  sc_res = abs_b;
      3'b011:  sc_res = abs_b;
      3'b100:  sc_res = addsub(b, a, 1'b0);
      3'b101:  sc_res = addsub(b, a, 1'b1);
      3'b110:  sc_res = abs_a;
      default: sc_res = addsub(acc_eff, a, 1'b0);
    endcase
  end

`ifdef SEQ_CALC_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_signed;
  logic               mul_ovf;

  // One shift-add step on magnitudes, then sign fix-up and range check.
  always_comb begin
    prod_step   = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_signed = neg_q ? (~prod_step + (2*WIDTH)'(1)) : prod_step;
    mul_ovf     = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
  end
`endif

  // Control FSM, datapath registers, accumulator and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
`ifdef SEQ_CALC_MUL_EN
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      if (deliver) begin
        acc_q <= r_q;
      end
      if (deliver & ovf_q) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_RESULT: begin
          if (deliver) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
          if (accept) begin
`ifdef SEQ_CALC_MUL_EN
            if (op == 3'b011) begin
              state_q     <= S_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              prod_q      <= '0;
              mcand_q     <= {WIDTH'(0), abs_a[WIDTH-1:0]};
              mplier_q    <= abs_b[WIDTH-1:0];
              neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
              cnt_q       <= '0;
            end else
`endif
            begin
              state_q     <= S_RESULT;
              out_valid_q <= 1'b1;
              r_q         <= sc_res[WIDTH-1:0];
              ovf_q       <= sc_res[WIDTH];
            end
          end
        end
`ifdef SEQ_CALC_MUL_EN
        S_MUL: begin
          prod_q   <= prod_step;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= S_RESULT;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            r_q         <= prod_signed[WIDTH-1:0];
            ovf_q       <= mul_ovf;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
